clock_monitor: RTL and testbench



---
 rtl/clock_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_clock_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Sysclk-domain monitor for the divided processor clock: measures high/low/period
// of slowclk_in in sysclk cycles, and flags lock against the expected ratio and stalls.
module clock_monitor #(
  parameter int unsigned SLOWDOWN   = 1000,
  parameter int unsigned TOLERANCE  = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 4 * SLOWDOWN
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        slowclk_in,
  input  logic        enable,
  output logic [31:0] high_cnt,
  output logic [31:0] low_cnt,
  output logic [31:0] period_cnt,
  output logic        meas_valid,
  output logic        in_tol,
  output logic        locked,
  output logic        stalled
);

  localparam logic [31:0] HALF      = 32'(SLOWDOWN / 2 + 1);
  localparam logic [31:0] PER       = 32'(2 * (SLOWDOWN / 2 + 1));
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [33:0] TOL_C     = 34'(TOLERANCE);
  localparam int          LW        = $clog2(LOCK_COUNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  state_t state, state_nxt;

  logic        s1, s2, s3;
  logic        rise, fall;
  logic [31:0] cnt;
  logic [31:0] high_reg;
  logic [LW-1:0] lock_cnt;
  logic [32:0] sum_wide;
  logic [31:0] period_sum;
  logic        tol_ok;
  logic        timeout_hit;
  logic        cnt_load;
  logic        take_high;
  logic        take_meas;
  logic        stall_set;

  function automatic logic within_tol(input logic [31:0] value, input logic [31:0] target);
    logic [33:0] v;
    logic [33:0] t;
    v = {2'b00, value};
    t = {2'b00, target};
    return ((v + TOL_C) >= t) && (v <= (t + TOL_C));
  endfunction

  // Two-flop synchroniser plus a third flop that only serves edge detection.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slowclk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign timeout_hit = (cnt >= TIMEOUT_C);
  assign sum_wide    = {1'b0, high_reg} + {1'b0, cnt};
  assign period_sum  = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
  assign tol_ok      = within_tol(high_reg, HALF) && within_tol(cnt, HALF) &&
                       within_tol(period_sum, PER);

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Edges take precedence over a coincident timeout; enable low overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    take_high = 1'b0;
    take_meas = 1'b0;
    stall_set = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_load  = 1'b1;
            state_nxt = MEAS_HIGH;
          end else if (timeout_hit) begin
            stall_set = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            cnt_load  = 1'b1;
            take_high = 1'b1;
            state_nxt = MEAS_LOW;
          end else if (timeout_hit) begin
            stall_set = 1'b1;
            state_nxt = WAIT_RISE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            cnt_load  = 1'b1;
            take_meas = 1'b1;
            state_nxt = MEAS_HIGH;
          end else if (timeout_hit) begin
            stall_set = 1'b1;
            state_nxt = WAIT_RISE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Cycle counter: restarts at 1 on a counted edge so a latched value equals
  // the distance between the two edge-detect pulses; saturates instead of wrapping.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      cnt <= 32'd0;
    end else if (!enable || state == IDLE) begin
      cnt <= 32'd0;
    end else if (cnt_load) begin
      cnt <= 32'd1;
    end else if (cnt != 32'hFFFF_FFFF) begin
      cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      high_reg <= 32'd0;
    end else if (take_high) begin
      high_reg <= cnt;
    end
  end

  // Published measurements hold across stalls and disables; only flags are cleared.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      high_cnt   <= 32'd0;
      low_cnt    <= 32'd0;
      period_cnt <= 32'd0;
      meas_valid <= 1'b0;
      in_tol     <= 1'b0;
    end else begin
      meas_valid <= take_meas;
      if (!enable) begin
        in_tol <= 1'b0;
      end else if (take_meas) begin
        high_cnt   <= high_reg;
        low_cnt    <= cnt;
        period_cnt <= period_sum;
        in_tol     <= tol_ok;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= '0;
      stalled  <= 1'b0;
    end else if (!enable) begin
      lock_cnt <= '0;
      stalled  <= 1'b0;
    end else begin
      if (stall_set) begin
        lock_cnt <= '0;
      end else if (take_meas) begin
        if (!tol_ok) begin
          lock_cnt <= '0;
        end else if (lock_cnt != LOCK_MAX) begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end
      if (rise && state != IDLE) begin
        stalled <= 1'b0;
      end else if (stall_set) begin
        stalled <= 1'b1;
      end
    end
  end

  assign locked = (lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: clean lock, duty distortion, tolerance
// boundary, stall/resume, enable drop and asynchronous reset mid-measurement.
module tb_clock_monitor;

  logic        sysclk;
  logic        rst;
  logic        slowclk_in;
  logic        enable;
  logic [31:0] high_cnt;
  logic [31:0] low_cnt;
  logic [31:0] period_cnt;
  logic        meas_valid;
  logic        in_tol;
  logic        locked;
  logic        stalled;

  int n_checks = 0;
  int n_fail   = 0;
  int mv_total = 0;

  bit          got;
  logic [31:0] cap_high;
  logic [31:0] cap_low;
  logic [31:0] cap_period;
  logic        cap_tol;
  logic        cap_locked;

  clock_monitor dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .slowclk_in (slowclk_in),
    .enable     (enable),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .in_tol     (in_tol),
    .locked     (locked),
    .stalled    (stalled)
  );

  initial sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (meas_valid) mv_total++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One slow-clock period, rising at a sysclk negedge; any report triggered by
  // this period's opening rise is captured during the high phase.
  task automatic apply_stimulus(input int h, input int l);
    got = 1'b0;
    slowclk_in = 1'b1;
    for (int i = 0; i < h; i++) begin
      @(negedge sysclk);
      if (meas_valid) begin
        got        = 1'b1;
        cap_high   = high_cnt;
        cap_low    = low_cnt;
        cap_period = period_cnt;
        cap_tol    = in_tol;
        cap_locked = locked;
      end
    end
    slowclk_in = 1'b0;
    repeat (l) @(negedge sysclk);
  endtask

  task automatic check_report(input string tag, input int h, input int l, input logic tol,
                              input logic lk);
    check_output({tag, "_valid"}, 32'(got), 32'd1);
    check_output({tag, "_high"}, cap_high, 32'(h));
    check_output({tag, "_low"}, cap_low, 32'(l));
    check_output({tag, "_period"}, cap_period, 32'(h + l));
    check_output({tag, "_in_tol"}, 32'(cap_tol), 32'(tol));
    check_output({tag, "_locked"}, 32'(cap_locked), 32'(lk));
  endtask

  initial begin
    int stall_wait;
    int mv_snap;

    rst = 1'b0;
    enable = 1'b0;
    slowclk_in = 1'b0;
    cap_high = '0; cap_low = '0; cap_period = '0; cap_tol = 1'b0; cap_locked = 1'b0;
    repeat (3) @(negedge sysclk);
    check_output("rst_high", high_cnt, 32'd0);
    check_output("rst_low", low_cnt, 32'd0);
    check_output("rst_period", period_cnt, 32'd0);
    check_output("rst_valid", 32'(meas_valid), 32'd0);
    check_output("rst_in_tol", 32'(in_tol), 32'd0);
    check_output("rst_locked", 32'(locked), 32'd0);
    check_output("rst_stalled", 32'(stalled), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge sysclk);

    $display("[TB] clean divider, lock acquisition");
    enable = 1'b1;
    repeat (10) @(negedge sysclk);
    apply_stimulus(501, 501);
    check_output("first_no_report", 32'(got), 32'd0);
    apply_stimulus(501, 501);
    check_report("clean1", 501, 501, 1'b1, 1'b0);
    apply_stimulus(501, 501);
    apply_stimulus(501, 501);
    check_report("clean3", 501, 501, 1'b1, 1'b0);
    apply_stimulus(501, 501);
    check_report("clean4", 501, 501, 1'b1, 1'b1);

    $display("[TB] duty distortion and relock");
    apply_stimulus(505, 497);
    check_report("pre_distort", 501, 501, 1'b1, 1'b1);
    apply_stimulus(501, 501);
    check_report("distort", 505, 497, 1'b0, 1'b0);
    apply_stimulus(501, 501);
    apply_stimulus(501, 501);
    apply_stimulus(501, 501);
    check_report("relock3", 501, 501, 1'b1, 1'b0);
    apply_stimulus(501, 501);
    check_report("relock4", 501, 501, 1'b1, 1'b1);

    $display("[TB] tolerance boundary");
    apply_stimulus(503, 501);
    apply_stimulus(504, 501);
    check_report("bound_in", 503, 501, 1'b1, 1'b1);
    apply_stimulus(501, 501);
    check_report("bound_out", 504, 501, 1'b0, 1'b0);
    repeat (4) apply_stimulus(501, 501);
    check_report("prestall_lock", 501, 501, 1'b1, 1'b1);

    // Stall: input rises at a negedge; rise is acted on 3 negedges later and
    // stalled becomes visible TIMEOUT cycles after that.
    $display("[TB] stall and resume");
    slowclk_in = 1'b1;
    stall_wait = 0;
    got = 1'b0;
    while (!stalled && stall_wait < 4100) begin
      @(negedge sysclk);
      stall_wait++;
      if (meas_valid) begin
        got = 1'b1;
        cap_locked = locked;
      end
    end
    check_output("stall_latency", 32'(stall_wait), 32'd4003);
    check_output("stall_flag", 32'(stalled), 32'd1);
    check_output("stall_unlock", 32'(locked), 32'd0);
    check_output("stall_prior_lock", 32'(cap_locked), 32'd1);
    check_output("stall_hold_period", period_cnt, 32'd1002);
    slowclk_in = 1'b0;
    repeat (501) @(negedge sysclk);
    check_output("stall_persist", 32'(stalled), 32'd1);
    apply_stimulus(501, 501);
    check_output("resume_no_report", 32'(got), 32'd0);
    check_output("resume_stall_clr", 32'(stalled), 32'd0);
    apply_stimulus(501, 501);
    apply_stimulus(501, 501);
    apply_stimulus(501, 501);
    check_report("resume3", 501, 501, 1'b1, 1'b0);
    apply_stimulus(501, 501);
    check_report("resume4", 501, 501, 1'b1, 1'b1);

    $display("[TB] enable dropped mid low phase");
    apply_stimulus(501, 200);
    mv_snap = mv_total;
    enable = 1'b0;
    @(negedge sysclk);
    check_output("dis_locked", 32'(locked), 32'd0);
    check_output("dis_in_tol", 32'(in_tol), 32'd0);
    check_output("dis_period_hold", period_cnt, 32'd1002);
    repeat (300) @(negedge sysclk);
    apply_stimulus(501, 501);
    check_output("dis_no_report", 32'(mv_total), 32'(mv_snap));
    enable = 1'b1;
    repeat (10) @(negedge sysclk);
    apply_stimulus(501, 501);
    check_output("reen_no_report", 32'(got), 32'd0);
    apply_stimulus(501, 501);
    check_report("reen1", 501, 501, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid high phase");
    slowclk_in = 1'b1;
    repeat (200) @(negedge sysclk);
    #3 rst = 1'b0;
    #1;
    check_output("arst_high", high_cnt, 32'd0);
    check_output("arst_period", period_cnt, 32'd0);
    check_output("arst_in_tol", 32'(in_tol), 32'd0);
    slowclk_in = 1'b0;
    repeat (5) @(negedge sysclk);
    rst = 1'b1;
    repeat (10) @(negedge sysclk);
    apply_stimulus(501, 501);
    check_output("arst_no_report", 32'(got), 32'd0);
    apply_stimulus(501, 501);
    check_report("arst1", 501, 501, 1'b1, 1'b0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
